// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the FIFO write port.
// The master modport is the arbiter's view; the slave modport is the requester/FIFO view.
interface fifo_wr_arbiter_if #(
    parameter int DATA_W = 3,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] reqData;
    logic                    fifoFull;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic                    fifoWrEn;
    logic [DATA_W-1:0]       fifoWrData;
    logic                    busy;

    modport master (
        input  req, reqData, fifoFull,
        output gnt, ack, fifoWrEn, fifoWrData, busy
    );

    modport slave (
        output req, reqData, fifoFull,
        input  gnt, ack, fifoWrEn, fifoWrData, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// One owner at a time writes up to BURST words; priority rotates after every release.
module fifo_wr_arbiter #(
    parameter int DATA_W = 3,
    parameter int N_REQ  = 4,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rstN,
    fifo_wr_arbiter_if.master bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BURST) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  w_owner_nxt;
    logic [IDX_W-1:0]  r_last_ptr;
    logic [IDX_W-1:0]  w_last_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    logic [DATA_W-1:0] w_words [N_REQ];
    logic [IDX_W-1:0]  w_sel;
    logic [IDX_W-1:0]  w_idx;
    logic              w_sel_vld;
    logic              w_own_req;
    logic              w_wr;
    logic              w_release;

    for (genvar k = 0; k < N_REQ; k++) begin : g_words
        assign w_words[k] = bus.reqData[k*DATA_W +: DATA_W];
    end

    // First requester in circular order after the last owner wins.
    always_comb begin
        w_sel     = r_last_ptr;
        w_sel_vld = 1'b0;
        w_idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = IDX_W'((int'(r_last_ptr) + i) % N_REQ);
            if (!w_sel_vld && bus.req[w_idx]) begin
                w_sel     = w_idx;
                w_sel_vld = 1'b1;
            end
        end
    end

    assign w_own_req = bus.req[r_owner];
    assign w_wr      = (r_state == S_OWN) && w_own_req && !bus.fifoFull;
    assign w_release = (r_state == S_OWN) &&
                       ((w_wr && (r_cnt == CNT_LAST)) || !w_own_req);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;
        unique case (r_state)
            S_IDLE: begin
                if (w_sel_vld) begin
                    w_state_nxt = S_OWN;
                    w_owner_nxt = w_sel;
                    w_cnt_nxt   = '0;
                    w_gnt_nxt   = N_REQ'(1) << w_sel;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_OWN: begin
                if (w_wr) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                // A stalled owner (fifoFull with req held) simply stays here.
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_owner;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_last_ptr <= LAST_IDX;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last_ptr <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.busy       = r_busy;
    assign bus.fifoWrEn   = w_wr;
    assign bus.ack        = w_wr ? (N_REQ'(1) << r_owner) : '0;
    assign bus.fifoWrData = w_wr ? w_words[r_owner] : '0;
endmodule
